// File: rtl/vend_fsm_param_if.sv
// Bundles the front-end (coin acceptor/keypad) and back-end (dispenser/hopper)
// signals of the vending controller into one port.
interface vend_fsm_param_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8
);
    logic                 coin_valid;
    logic [CREDIT_W-1:0]  coin_value;
    logic                 choice_valid;
    logic [NUM_ITEMS-1:0] choice;
    logic                 cancel;
    logic [NUM_ITEMS-1:0] vend;
    logic [CREDIT_W-1:0]  credit;
    logic [1:0]           state;
    logic                 change_valid;
    logic [CREDIT_W-1:0]  change_amount;
    logic                 coin_reject;
    logic                 select_error;

    modport master (
        output coin_valid, coin_value, choice_valid, choice, cancel,
        input  vend, credit, state, change_valid, change_amount,
               coin_reject, select_error
    );

    modport slave (
        input  coin_valid, coin_value, choice_valid, choice, cancel,
        output vend, credit, state, change_valid, change_amount,
               coin_reject, select_error
    );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit accumulation, per-item prices, change and refund.
// Define VEND_CHANGE_SERIAL_EN to pay change one COIN_UNIT per cycle instead of as one lump.
module vend_fsm_param #(
    parameter int                          NUM_ITEMS  = 4,
    parameter int                          CREDIT_W   = 8,
    parameter int                          COIN_UNIT  = 10,
    parameter int                          MAX_CREDIT = 50,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES   = {8'd30, 8'd40, 8'd40, 8'd30}
) (
    input logic             clock,
    input logic             reset,
    vend_fsm_param_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [NUM_ITEMS-1:0] vend_q, vend_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amount_q, change_amount_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 select_error_q, select_error_d;

    logic [CREDIT_W:0]    coinSum;
    logic                 coinOk;
    logic [CREDIT_W-1:0]  price;
    logic [CREDIT_W-1:0]  remaining;
    logic                 acceptCancel;
    logic                 takeCoin;

    // Amount paid in a single change strobe.
    function automatic logic [CREDIT_W-1:0] chunk(input logic [CREDIT_W-1:0] amount);
`ifdef VEND_CHANGE_SERIAL_EN
        chunk = (amount > CREDIT_W'(COIN_UNIT)) ? CREDIT_W'(COIN_UNIT) : amount;
`else
        chunk = amount;
`endif
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            credit_q        <= '0;
            vend_q          <= '0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            select_error_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            vend_q          <= vend_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            select_error_q  <= select_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        vend_d          = '0;
        change_valid_d  = 1'b0;
        change_amount_d = '0;
        coin_reject_d   = 1'b0;
        select_error_d  = 1'b0;
        takeCoin        = 1'b0;
        acceptCancel    = 1'b0;
        remaining       = credit_q - change_amount_q;

        // Sum is one bit wider so an oversized coin cannot wrap under the ceiling.
        coinSum = {1'b0, credit_q} + {1'b0, bus.coin_value};
        coinOk  = (bus.coin_value != '0) && (coinSum <= (CREDIT_W+1)'(MAX_CREDIT));

        price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (bus.choice[i]) price = PRICES[i*CREDIT_W +: CREDIT_W];
        end

        case (state_q)
            IDLE, CREDIT: begin
                acceptCancel = bus.cancel && (state_q == CREDIT);
                if (acceptCancel) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = chunk(credit_q);
                end else if (bus.choice_valid) begin
                    if ((state_q == CREDIT) && $onehot(bus.choice) && (credit_q >= price)) begin
                        state_d  = VEND;
                        credit_d = credit_q - price;
                        vend_d   = bus.choice;
                    end else begin
                        select_error_d = 1'b1;
                        takeCoin       = 1'b1;
                    end
                end else begin
                    takeCoin = 1'b1;
                end

                if (bus.coin_valid) begin
                    if (takeCoin && coinOk) begin
                        credit_d = coinSum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            VEND: begin
                coin_reject_d = bus.coin_valid;
                if (credit_q != '0) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = chunk(credit_q);
                end else begin
                    state_d = IDLE;
                end
            end

            CHANGE: begin
                // Credit shown during a strobe still includes that strobe's amount.
                coin_reject_d = bus.coin_valid;
                credit_d      = remaining;
                if (remaining != '0) begin
                    change_valid_d  = 1'b1;
                    change_amount_d = chunk(remaining);
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.vend          = vend_q;
    assign bus.credit        = credit_q;
    assign bus.state         = state_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amount = change_amount_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.select_error  = select_error_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: directed plan scenarios, then random traffic
// compared against a transaction-level model that schedules future output frames.
module tb_vend_fsm_param;

    logic clock;
    logic reset;

    vend_fsm_param_if #(.NUM_ITEMS(4), .CREDIT_W(8)) bus ();

    vend_fsm_param dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] vend;
        logic       cv;
        logic [7:0] amt;
        logic [7:0] credit;
        logic [1:0] st;
    } frame_t;

    int     prices [4] = '{30, 40, 40, 30};
    int     coinChoices [10] = '{10, 20, 10, 20, 30, 50, 0, 5, 60, 255};
    frame_t pend [$];
    frame_t expFrame;
    logic   expReject;
    logic   expSelErr;
    int     mCredit;
    int     assertCount;
    int     failCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int priceOf(input logic [3:0] ch);
        int p = 0;
        for (int i = 0; i < 4; i++) if (ch[i]) p = prices[i];
        return p;
    endfunction

    function automatic frame_t mkFrame(input logic [3:0] v, input logic cv, input int amt,
                                       input int cr, input logic [1:0] st);
        frame_t f;
        f.vend = v; f.cv = cv; f.amt = 8'(amt); f.credit = 8'(cr); f.st = st;
        return f;
    endfunction

    // Refund of 'amount': lump payout, or COIN_UNIT-sized strobes with a final remainder.
    task automatic pushChange(input int amount);
`ifdef VEND_CHANGE_SERIAL_EN
        int rem = amount;
        while (rem > 0) begin
            int a = (rem > 10) ? 10 : rem;
            pend.push_back(mkFrame(4'b0, 1'b1, a, rem, 2'd3));
            rem -= a;
        end
`else
        pend.push_back(mkFrame(4'b0, 1'b1, amount, amount, 2'd3));
`endif
    endtask

    task automatic modelStep(input logic cv, input int cval, input logic chv,
                             input logic [3:0] ch, input logic can);
        bit took = 0;
        expReject = 1'b0;
        expSelErr = 1'b0;
        if (pend.size() > 0) begin
            expFrame  = pend.pop_front();
            expReject = cv;
        end else begin
            if (can && mCredit > 0) begin
                pushChange(mCredit);
                pend.push_back(mkFrame(4'b0, 1'b0, 0, 0, 2'd0));
                expFrame = pend.pop_front();
                mCredit  = 0;
                took     = 1;
            end else if (chv) begin
                if (mCredit > 0 && $countones(ch) == 1 && mCredit >= priceOf(ch)) begin
                    int rem = mCredit - priceOf(ch);
                    expFrame = mkFrame(ch, 1'b0, 0, rem, 2'd2);
                    if (rem > 0) pushChange(rem);
                    pend.push_back(mkFrame(4'b0, 1'b0, 0, 0, 2'd0));
                    mCredit = 0;
                    took    = 1;
                end else begin
                    expSelErr = 1'b1;
                end
            end
            if (cv) begin
                if (!took && cval != 0 && mCredit + cval <= 50) mCredit += cval;
                else expReject = 1'b1;
            end
            if (!took) expFrame = mkFrame(4'b0, 1'b0, 0, mCredit, (mCredit > 0) ? 2'd1 : 2'd0);
        end
    endtask

    task automatic compareAll();
        checkOutput("vend",          32'(bus.vend),          32'(expFrame.vend));
        checkOutput("credit",        32'(bus.credit),        32'(expFrame.credit));
        checkOutput("state",         32'(bus.state),         32'(expFrame.st));
        checkOutput("change_valid",  32'(bus.change_valid),  32'(expFrame.cv));
        checkOutput("change_amount", 32'(bus.change_amount), 32'(expFrame.amt));
        checkOutput("coin_reject",   32'(bus.coin_reject),   32'(expReject));
        checkOutput("select_error",  32'(bus.select_error),  32'(expSelErr));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vend"},   32'(bus.vend),          32'd0);
        checkOutput({tag, "_credit"}, 32'(bus.credit),        32'd0);
        checkOutput({tag, "_state"},  32'(bus.state),         32'd0);
        checkOutput({tag, "_cv"},     32'(bus.change_valid),  32'd0);
        checkOutput({tag, "_amt"},    32'(bus.change_amount), 32'd0);
        checkOutput({tag, "_rej"},    32'(bus.coin_reject),   32'd0);
        checkOutput({tag, "_serr"},   32'(bus.select_error),  32'd0);
    endtask

    // One clock cycle: drive at the falling edge, check #1 after the rising edge.
    task automatic applyStimulus(input logic cv, input int cval, input logic chv,
                                 input logic [3:0] ch, input logic can);
        @(negedge clock);
        bus.coin_valid   = cv;
        bus.coin_value   = 8'(cval);
        bus.choice_valid = chv;
        bus.choice       = ch;
        bus.cancel       = can;
        @(posedge clock);
        modelStep(cv, cval, chv, ch, can);
        #1;
        compareAll();
    endtask

    task automatic coin(input int v);
        applyStimulus(1'b1, v, 1'b0, 4'b0, 1'b0);
    endtask

    task automatic choose(input logic [3:0] ch);
        applyStimulus(1'b0, 0, 1'b1, ch, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 4'b0, 1'b0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        mCredit     = 0;
        bus.coin_valid   = 1'b0;
        bus.coin_value   = '0;
        bus.choice_valid = 1'b0;
        bus.choice       = '0;
        bus.cancel       = 1'b0;
        reset = 1'b1;
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        coin(20); coin(20); choose(4'b0010); idleCycles(2);
        coin(20); coin(20); coin(10); choose(4'b0001); idleCycles(4);
        coin(20); coin(20); coin(20); coin(0);
        applyStimulus(1'b0, 0, 1'b0, 4'b0, 1'b1); idleCycles(5);
        coin(20); choose(4'b0100); choose(4'b0011); choose(4'b0000);
        coin(10);
        applyStimulus(1'b1, 10, 1'b1, 4'b0001, 1'b1); idleCycles(4);
        choose(4'b0001);
        applyStimulus(1'b1, 10, 1'b1, 4'b1000, 1'b0); idleCycles(1);
        applyStimulus(1'b0, 0, 1'b0, 4'b0, 1'b1); idleCycles(4);

        // Reset while change is being paid out.
        coin(50);
        applyStimulus(1'b0, 0, 1'b0, 4'b0, 1'b1);
        #2 reset = 1'b1;
        #1 checkAllZero("midreset");
        @(negedge clock);
        reset = 1'b0;
        pend.delete();
        mCredit = 0;
        idleCycles(1);

        for (int n = 0; n < 600; n++) begin
            logic       cv  = ($urandom_range(0, 99) < 50);
            int         cvl = coinChoices[$urandom_range(0, 9)];
            logic       chv = ($urandom_range(0, 99) < 25);
            logic [3:0] ch  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'(1 << $urandom_range(0, 3));
            logic       can = ($urandom_range(0, 99) < 8);
            applyStimulus(cv, cvl, chv, ch, can);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending-machine controller: next generation of the fixed four-item, two-coin vend FSM. It accumulates credit from valued coin events and vends one of `NUM_ITEMS` items at per-item prices. It returns change and supports cancel/refund with a registered, single-clock datapath. It sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

## Interface
- `NUM_ITEMS`, 4: number of selectable items.
- `CREDIT_W`, 8: width of credit, coin and price values.
- `COIN_UNIT`, 10: denomination of one change-hopper coin.
- `MAX_CREDIT`, 50: credit ceiling; coins that would exceed it are rejected.
- `PRICES`, {8'd30,8'd40,8'd40,8'd30}: packed `NUM_ITEMS*CREDIT_W` prices; item i at bits [i*CREDIT_W +: CREDIT_W]. Item 0 is candy, 1 drink, 2 coffee, 3 snack.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `coin_valid`  in  1  one-cycle coin event.
- `coin_value`  in  CREDIT_W  value of the inserted coin.
- `choice_valid`  in  1  one-cycle selection event.
- `choice`  in  NUM_ITEMS  one-hot item select.
- `cancel`  in  1  level/pulse refund request.
- `vend`  out  NUM_ITEMS  one-hot dispense pulse.
- `credit`  out  CREDIT_W  current credit.
- `state`  out  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
- `change_valid`  out  1  change output strobe.
- `change_amount`  out  CREDIT_W  change value for this strobe.
- `coin_reject`  out  1  one-cycle pulse: coin returned.
- `select_error`  out  1  one-cycle pulse: selection refused.

## Operation
- Reset: state IDLE; every output 0.
- In IDLE or CREDIT, per-cycle priority is cancel > choice_valid > coin_valid.
- Coin accept: requires coin_value != 0 and coin_value + credit <= MAX_CREDIT. The sum is computed at CREDIT_W+1 bits, with no wrap. On accept, credit += coin_value and state goes to CREDIT. Otherwise coin_reject pulses and credit is unchanged.
- A coin arriving in the same cycle as an accepted cancel/choice, or in VEND/CHANGE, is rejected.
- Choice in CREDIT is accepted when choice is exactly one-hot and credit >= price. On accept: state VEND, credit -= price. Otherwise select_error pulses and state/credit are held.
- Choice in IDLE always pulses select_error.
- VEND lasts one cycle with vend = choice latched at acceptance. Next state is CHANGE if credit > 0, else IDLE.
- Cancel in CREDIT goes to CHANGE with the full credit. Cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE: change is dispensed (see Configuration) and credit decrements to 0, then IDLE.
- choice_valid/cancel in VEND/CHANGE are ignored; no select_error.

## Timing
- All outputs are registered. An event sampled at edge N is reflected at N+1.
- coin_reject and select_error are high exactly one cycle, at N+1.
- Accepted choice at N: vend high during cycle N+1 only. change_valid begins at N+2 if credit remains.
- change_valid is high only while state==CHANGE. change_amount is 0 when change_valid is low.
- Reset mid-VEND/CHANGE aborts immediately. Pending credit is discarded and outputs clear asynchronously.

## Configuration
- `VEND_CHANGE_SERIAL_EN` undefined: CHANGE lasts one cycle with change_valid=1 and change_amount=credit. Credit becomes 0.
- `VEND_CHANGE_SERIAL_EN` defined: one strobe per cycle with change_amount = min(credit, COIN_UNIT), and credit reduces by that amount. CHANGE lasts ceil(credit/COIN_UNIT) cycles; the final strobe carries any sub-unit remainder.

## Test plan
- Reset, then coins 20,20 and choose item 1 (40) -> credit 20, 40; vend=4'b0010 one cycle; no change_valid; IDLE.
- Coins 20,20,10 and choose item 0 (30) -> vend=4'b0001. Change 20: lump gives one strobe of 20; serial gives two strobes of 10.
- Credit 40 plus coin 20 -> coin_reject one cycle, credit stays 40. Coin 0 -> rejected.
- Credit 20, choose item 2 (40) -> select_error one cycle, state CREDIT, credit 20. choice=4'b0011 -> select_error.
- Credit 30, cancel together with choice_valid and coin_valid -> no vend, coin_reject, CHANGE refunding 30.
- Assert reset during serial CHANGE -> all outputs 0 immediately, IDLE, credit 0.
